// File: rtl/data_sramlike_responder.sv
// data_sramlike_responder: sram-like data bus slave that fronts a single-port data SRAM with a programmable completion latency.
module data_sramlike_responder #(
    parameter int LATENCY = 2,
    parameter int DEPTH = 2,
    parameter int ADDR_OK_GAP = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [2:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic [1:0]  data_ex,
    input  logic [1:0]  tlb_ex,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        ram_en,
    output logic [3:0]  ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);
    localparam int CW = LATENCY > 1 ? LATENCY - 1 : 1;
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);
    localparam logic [2:0] GAP_C = 3'(ADDR_OK_GAP);
    logic [2:0] count_q, count_d, gap_q, gap_d;
    logic [LATENCY-1:0] vld_q, vld_d, wr_q, wr_d;
    logic [31:0] cap_q [CW];
    logic [31:0] cap_d [CW];
    logic hs, acc;
    logic [1:0] a;
    logic [3:0] wen;

    assign a = data_addr[1:0];
    assign data_data_ok = resetn && vld_q[LATENCY-1];
    assign data_addr_ok = resetn && gap_q == 3'd0 && (count_q < DEPTH_C || data_data_ok);
    assign hs = data_req && data_addr_ok;
    assign acc = hs && tlb_ex == 2'b00;
    assign data_ex = hs ? tlb_ex : 2'b00;
    assign ram_en = acc;
    assign ram_addr = {data_addr[31:2], 2'b00};
    assign ram_wdata = data_wdata;
    // cap_q[i] holds the read word of the entry sitting in vld_q[i+1]; LATENCY 1 returns the SRAM output directly
    assign data_rdata = data_data_ok && !wr_q[LATENCY-1] ? (LATENCY == 1 ? ram_rdata : cap_q[CW-1]) : 32'd0;

    always_comb begin
        wen = data_size == 3'b000 ? 4'b0001 << a :
              data_size == 3'b001 ? (a[1] ? 4'b1100 : 4'b0011) :
              data_size == 3'b010 ? 4'b1111 :
              data_size == 3'b100 ? 4'b1111 >> ~a :
              data_size == 3'b101 ? 4'b1111 << a : 4'b0000;
        ram_wen = acc && data_wr ? wen : 4'b0000;
    end

    always_comb begin
        count_d = count_q + {2'b00, acc} - {2'b00, data_data_ok};
        gap_d = hs ? GAP_C : gap_q - (gap_q != 3'd0 ? 3'd1 : 3'd0);
        vld_d = vld_q << 1;
        vld_d[0] = acc;
        wr_d = wr_q << 1;
        wr_d[0] = data_wr;
        cap_d[0] = ram_rdata;
        for (int i = 1; i < CW; i++) cap_d[i] = cap_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= '0;
            gap_q <= '0;
            vld_q <= '0;
            wr_q <= '0;
            for (int i = 0; i < CW; i++) cap_q[i] <= '0;
        end else begin
            count_q <= count_d;
            gap_q <= gap_d;
            vld_q <= vld_d;
            wr_q <= wr_d;
            cap_q <= cap_d;
        end
    end
endmodule

// File: tb/tb_data_sramlike_responder.sv
// tb_data_sramlike_responder: three responder configurations, each behind its own SRAM model, checked by vectors and a completion scoreboard.
module tb_data_sramlike_responder;
    typedef struct {logic wr; logic [2:0] size; logic [31:0] addr, wdata; logic [3:0] wen; logic [31:0] rdata;} vec_t;
    typedef struct {logic [31:0] data; int due;} exp_t;

    logic clk = 0, resetn = 0, init = 1;
    logic [2:0] req = '0;
    logic wr = 0;
    logic [2:0] size = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic [1:0] tlb = '0;
    logic [2:0] addr_ok, data_ok, ram_en;
    logic [1:0] dex [3];
    logic [31:0] rdata [3];
    logic [31:0] raddr [3];
    logic [31:0] rwdata [3];
    logic [3:0] wen [3];
    exp_t sb [3][$];
    exp_t e;
    int cyc = 0, checks = 0, passes = 0, mchecks = 0, mpasses = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : gi
        logic [31:0] mem [128];
        logic [31:0] rd;
        data_sramlike_responder #(.LATENCY(g == 1 ? 4 : 2), .DEPTH(2), .ADDR_OK_GAP(g == 2 ? 3 : 0)) dut (
            .clk(clk), .resetn(resetn), .data_req(req[g]), .data_wr(wr), .data_size(size),
            .data_addr(addr), .data_wdata(wdata), .data_addr_ok(addr_ok[g]), .data_ex(dex[g]),
            .tlb_ex(tlb), .data_data_ok(data_ok[g]), .data_rdata(rdata[g]), .ram_en(ram_en[g]),
            .ram_wen(wen[g]), .ram_addr(raddr[g]), .ram_wdata(rwdata[g]), .ram_rdata(rd)
        );
        always @(posedge clk) begin
            if (init) begin
                for (int i = 0; i < 128; i++) mem[i] <= i == 64 ? 32'hDEADBEEF : 32'hC0DE0000 | 32'(i * 4);
            end else if (ram_en[g]) begin
                for (int b = 0; b < 4; b++) if (wen[g][b]) mem[raddr[g][8:2]][8*b +: 8] <= rwdata[g][8*b +: 8];
                rd <= mem[raddr[g][8:2]];
            end
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (data_ok[g]) begin
                mchecks++;
                if (sb[g].size() == 0) $display("FAIL sb%0d unexpected data_ok rdata=%h at cycle %0d", g, rdata[g], cyc);
                else begin
                    e = sb[g].pop_front();
                    if (rdata[g] === e.data && cyc == e.due) mpasses++;
                    else $display("FAIL sb%0d completion: got %h at cycle %0d, expected %h at cycle %0d", g, rdata[g], cyc, e.data, e.due);
                end
            end
        end
    end

    function automatic int lat(input int g);
        return g == 1 ? 4 : 2;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", n, act, exp);
    endtask

    task automatic issue(input int g, input logic w, input logic [2:0] s, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] t, input logic [31:0] er, output logic en_o, output logic [3:0] wen_o,
                         output logic [1:0] ex_o, output logic [31:0] ra_o, output int waited);
        @(posedge clk);
        #1;
        req[g] = 1;
        wr = w;
        size = s;
        addr = a;
        wdata = d;
        tlb = t;
        waited = 0;
        @(negedge clk);
        while (!addr_ok[g] && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        en_o = ram_en[g];
        wen_o = wen[g];
        ex_o = dex[g];
        ra_o = raddr[g];
        if (!addr_ok[g]) chk("handshake_timeout", 0, 1);
        else if (t == 2'b00) sb[g].push_back(exp_t'{er, cyc + lat(g)});
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        req = '0;
    endtask

    vec_t v [19];
    logic en;
    logic [3:0] w;
    logic [1:0] x;
    logic [31:0] ra;
    int n;
    logic h;
    logic [9:0] pat;

    initial begin
        v[0]  = '{1'b0, 3'b010, 32'h100, 32'h0,        4'b0000, 32'hDEADBEEF};
        v[1]  = '{1'b1, 3'b000, 32'h103, 32'h11111111, 4'b1000, 32'h0};
        v[2]  = '{1'b1, 3'b001, 32'h102, 32'h22222222, 4'b1100, 32'h0};
        v[3]  = '{1'b1, 3'b100, 32'h101, 32'h33333333, 4'b0011, 32'h0};
        v[4]  = '{1'b1, 3'b101, 32'h101, 32'h44444444, 4'b1110, 32'h0};
        v[5]  = '{1'b1, 3'b000, 32'h100, 32'h55555555, 4'b0001, 32'h0};
        v[6]  = '{1'b1, 3'b011, 32'h100, 32'h66666666, 4'b0000, 32'h0};
        v[7]  = '{1'b0, 3'b010, 32'h100, 32'h0,        4'b0000, 32'h44444455};
        v[8]  = '{1'b1, 3'b100, 32'h107, 32'h77777777, 4'b1111, 32'h0};
        v[9]  = '{1'b1, 3'b101, 32'h104, 32'h88888888, 4'b1111, 32'h0};
        v[10] = '{1'b1, 3'b001, 32'h104, 32'h99999999, 4'b0011, 32'h0};
        v[11] = '{1'b0, 3'b000, 32'h105, 32'h0,        4'b0000, 32'h88889999};
        v[12] = '{1'b1, 3'b100, 32'h10A, 32'hAAAAAAAA, 4'b0111, 32'h0};
        v[13] = '{1'b1, 3'b101, 32'h10B, 32'hBBBBBBBB, 4'b1000, 32'h0};
        v[14] = '{1'b0, 3'b001, 32'h10A, 32'h0,        4'b0000, 32'hBBAAAAAA};
        v[15] = '{1'b1, 3'b000, 32'h10E, 32'hCCCCCCCC, 4'b0100, 32'h0};
        v[16] = '{1'b0, 3'b010, 32'h10C, 32'h0,        4'b0000, 32'hC0CC010C};
        v[17] = '{1'b1, 3'b010, 32'h1F0, 32'h12345678, 4'b1111, 32'h0};
        v[18] = '{1'b0, 3'b010, 32'h1F0, 32'h0,        4'b0000, 32'h12345678};

        repeat (2) @(posedge clk);
        #1;
        init = 0;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("reset addr_ok%0d", g), addr_ok[g], 0);
            chk($sformatf("reset data_ok%0d", g), data_ok[g], 0);
            chk($sformatf("reset ram_en%0d", g), ram_en[g], 0);
            chk($sformatf("reset rdata%0d", g), rdata[g], 0);
        end
        @(posedge clk);
        #1;
        resetn = 1;
        @(negedge clk);
        for (int g = 0; g < 3; g++) chk($sformatf("post-reset addr_ok%0d", g), addr_ok[g], 1);

        for (int i = 0; i < 19; i++) begin
            issue(0, v[i].wr, v[i].size, v[i].addr, v[i].wdata, 2'b00, v[i].rdata, en, w, x, ra, n);
            chk($sformatf("vec%0d wen", i), w, v[i].wen);
            chk($sformatf("vec%0d ram_en", i), en, 1);
            chk($sformatf("vec%0d ram_addr", i), ra, v[i].addr & 32'hFFFFFFFC);
            chk($sformatf("vec%0d data_ex", i), x, 0);
            chk($sformatf("vec%0d stall", i), n, 0);
        end
        idle();
        tlb = 2'b11;
        repeat (4) @(negedge clk);
        chk("idle data_ex", dex[0], 0);
        chk("idle addr_ok", addr_ok[0], 1);
        chk("idle ram_en", ram_en[0], 0);

        issue(0, 1'b1, 3'b010, 32'h1F0, 32'hFFFFFFFF, 2'b01, 32'h0, en, w, x, ra, n);
        chk("fault01 data_ex", x, 2'b01);
        chk("fault01 ram_en", en, 0);
        chk("fault01 wen", w, 0);
        issue(0, 1'b0, 3'b010, 32'h1F0, 32'h0, 2'b10, 32'h0, en, w, x, ra, n);
        chk("fault10 data_ex", x, 2'b10);
        chk("fault10 stall", n, 0);
        issue(0, 1'b0, 3'b010, 32'h1F0, 32'h0, 2'b11, 32'h0, en, w, x, ra, n);
        chk("fault11 data_ex", x, 2'b11);
        chk("fault11 stall", n, 0);
        issue(0, 1'b0, 3'b010, 32'h1F0, 32'h0, 2'b00, 32'h12345678, en, w, x, ra, n);
        chk("post-fault ram_en", en, 1);
        chk("post-fault stall", n, 0);
        idle();
        repeat (4) @(negedge clk);

        pat = 10'b1100110011;
        @(posedge clk);
        #1;
        req[1] = 1;
        wr = 0;
        size = 3'b010;
        tlb = 2'b00;
        addr = 32'h0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            h = addr_ok[1];
            chk($sformatf("depth addr_ok c%0d", c), h, pat[c]);
            if (h) sb[1].push_back(exp_t'{32'hC0DE0000 | addr, cyc + 4});
            @(posedge clk);
            #1;
            if (h) addr = addr + 32'd4;
        end
        req[1] = 0;

        addr = 32'h40;
        req[2] = 1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            h = addr_ok[2];
            chk($sformatf("gap addr_ok c%0d", c), h, c % 4 == 0);
            if (h) sb[2].push_back(exp_t'{32'hC0DE0040, cyc + 2});
            @(posedge clk);
            #1;
        end
        req[2] = 0;
        repeat (6) @(negedge clk);

        issue(0, 1'b0, 3'b010, 32'h1F0, 32'h0, 2'b00, 32'h12345678, en, w, x, ra, n);
        issue(0, 1'b0, 3'b010, 32'h100, 32'h0, 2'b00, 32'h44444455, en, w, x, ra, n);
        @(posedge clk);
        #1;
        resetn = 0;
        req = '0;
        for (int g = 0; g < 3; g++) sb[g].delete();
        @(negedge clk);
        chk("mid-reset addr_ok", addr_ok[0], 0);
        chk("mid-reset data_ok", data_ok[0], 0);
        chk("mid-reset rdata", rdata[0], 0);
        @(posedge clk);
        #1;
        resetn = 1;
        @(negedge clk);
        chk("after-reset addr_ok", addr_ok[0], 1);
        repeat (6) @(negedge clk);
        issue(0, 1'b0, 3'b010, 32'h1F0, 32'h0, 2'b00, 32'h12345678, en, w, x, ra, n);
        chk("after-reset stall a", n, 0);
        issue(0, 1'b0, 3'b010, 32'h1F0, 32'h0, 2'b00, 32'h12345678, en, w, x, ra, n);
        chk("after-reset stall b", n, 0);
        idle();

        repeat (8) @(negedge clk);
        for (int g = 0; g < 3; g++) chk($sformatf("sb%0d drained", g), sb[g].size(), 0);
        $display("%0d/%0d checks passed", passes + mpasses, checks + mchecks);
        $finish;
    end
endmodule

// File: doc/data_sramlike_responder.md
Name: data_sramlike_responder

Overview:
- Slave/responder end of the data-side sram-like bus that the execute stage drives (data_req/wr/size/addr/wdata, addr_ok, ex).
- Sits between the pipeline and a synchronous single-port data SRAM.
- Accepts address phases, generates byte enables (including SWL/SWR sizes), delays completions by a programmable latency and returns in-order data_ok/rdata to the memory stage.
- Injects address-phase backpressure for stall testing.

Parameters:
LATENCY, 2, cycles from address handshake to data_ok (legal 1..4); 1 means data_ok in the cycle after the handshake
DEPTH, 2, max outstanding accepted-but-not-completed requests (legal 1..4)
ADDR_OK_GAP, 0, cycles addr_ok is forced low after each handshake (0..7)

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
data_req  in  1  request valid from execute stage
data_wr  in  1  1=store, 0=load
data_size  in  3  000 byte, 001 half, 010 word, 100 SWL, 101 SWR
data_addr  in  32  byte address
data_wdata  in  32  store data, already lane-aligned by initiator
data_addr_ok  out  1  address phase accepted when data_req && data_addr_ok
data_ex  out  2  00 none, 01 refill, 10 invalid, 11 modified; valid with addr_ok
tlb_ex  in  2  same-cycle translation fault code for data_addr
data_data_ok  out  1  completion pulse, in request order
data_rdata  out  32  aligned word read data, valid with data_data_ok (0 for stores)
ram_en  out  1  SRAM enable
ram_wen  out  4  SRAM byte write enables
ram_addr  out  32  word address {data_addr[31:2],2'b00}
ram_wdata  out  32  = data_wdata
ram_rdata  in  32  SRAM read data, one cycle after ram_en

Behaviour:
- Reset (resetn=0 at posedge): outstanding count 0, delay line cleared, gap counter 0. Outputs: data_addr_ok=0 during reset, data_data_ok=0, data_rdata=0, ram_en=0, ram_wen=0, data_ex=0.
- data_addr_ok (combinational) = gap_cnt==0 && (count<DEPTH || data_data_ok). It may be high without data_req.
- data_ex (combinational) = tlb_ex when data_req && data_addr_ok, else 00.
- Handshake (hs) = data_req && data_addr_ok.
  - On hs with tlb_ex!=00: no SRAM access, no delay-line entry, no data_ok ever. The gap counter still reloads.
  - On hs with tlb_ex==00: ram_en=1 in the same cycle. ram_wen per encoding (a=data_addr[1:0]):
    - byte: 0001<<a
    - half: a[1]?1100:0011
    - word: 1111
    - SWL: a=00→0001, 01→0011, 10→0111, 11→1111
    - SWR: a=00→1111, 01→1110, 10→1100, 11→1000
    - any load or illegal size: 0000 (illegal-size store writes nothing but still completes)
- Delay line: LATENCY stages of {valid, wr}. Capture ram_rdata in the stage after hs; hold it in its stage until exit. Stage LATENCY valid drives data_data_ok=1 for exactly one cycle; data_rdata = captured word for loads, 0 for stores. The initiator never backpressures data_ok.
- count: +1 on successful hs (tlb_ex==00), −1 on data_data_ok, unchanged when both occur. Never exceeds DEPTH. Completion and new accept in the same cycle are allowed at count==DEPTH.
- gap_cnt: loads ADDR_OK_GAP on any hs, decrements to 0.
- Throughput: with ADDR_OK_GAP=0 and DEPTH≥LATENCY, one request per cycle sustained.
- No reordering. Read-after-write to the same word in consecutive handshakes returns the new data, because the SRAM write occurs in the hs cycle.
- Reset mid-transfer: all in-flight entries are discarded; no data_ok after reset.
- Inputs are ignored while data_req=0. data_wdata/size/addr are sampled only at hs.

Test Plan:
- Default params, load word at 0x100 with ram holding 0xDEADBEEF → ram_en, ram_wen=0000 at hs cycle T; data_data_ok at T+2 with data_rdata=0xDEADBEEF.
- Stores: SB addr 0x103 → ram_wen=1000. SH addr 0x102 → 1100. SWL addr 0x101 → 0011. SWR addr 0x101 → 1110. Each yields data_data_ok two cycles later with rdata=0.
- DEPTH=2, LATENCY=4, req held high for 6 cycles → addr_ok high for first 2 hs, low until first data_ok, then one accept per completion. data_ok order matches issue order (addresses 0x0,0x4,0x8… readback tags).
- ADDR_OK_GAP=3, req held high → hs spaced every 4 cycles; addr_ok low exactly 3 cycles after each hs.
- tlb_ex=01 with req → data_ex=01 during hs, ram_en=0, count unchanged, no data_ok. Following clean request completes normally at its own latency.
- resetn low for 1 cycle while 2 requests are in flight → no data_ok afterwards; count=0. addr_ok=0 during reset, then high the first cycle after.
